// File: rtl/mul_div_unit_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    function automatic logic is_div_op(input op_e op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mul_div_iter.sv
// One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
module mul_div_iter
    import mul_div_unit_pkg::*;
(
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic               q_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] rem_trial;
    logic             ge;

    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand & {WIDTH{acc[0]}}};
        // Shifted remainder is WIDTH+1 bits; the difference fits WIDTH bits whenever it is non-negative.
        ge        = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, operand};
        rem_trial = acc[2*WIDTH-2:WIDTH-1] - operand;
        q_bit     = 1'b0;
        acc_nxt   = {sum, acc[WIDTH-1:1]};
        if (div_mode) begin
            q_bit   = ge;
            acc_nxt = {(ge ? rem_trial : acc[2*WIDTH-2:WIDTH-1]), acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with start/busy/done handshake and fixed latency.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state, next_state;
    op_e                op_r;
    logic [WIDTH-1:0]   a_r, b_r, opnd;
    logic [2*WIDTH-1:0] acc, acc_iter;
    logic [CNT_W-1:0]   count;
    logic               sign_a, sign_b, q_bit;
    logic               busy_nxt, done_nxt;
    logic               div_c, neg_a_c, neg_b_c, dz_c;
    logic [WIDTH-1:0]   mag_a_c, mag_b_c;

    assign div_c   = is_div_op(op_r);
    assign neg_a_c = is_signed_op(op_r) & a_r[WIDTH-1];
    assign neg_b_c = is_signed_op(op_r) & b_r[WIDTH-1];
    assign mag_a_c = neg_a_c ? -a_r : a_r;
    assign mag_b_c = neg_b_c ? -b_r : b_r;
    assign dz_c    = div_c && (b_r == '0);

    mul_div_iter u_iter (
        .acc      (acc),
        .operand  (opnd),
        .div_mode (div_c),
        .acc_nxt  (acc_iter),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Divide-by-zero still passes through FIX so its done lands two cycles after acceptance.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = PREP;
            PREP:    next_state = dz_c ? FIX : RUN;
            RUN:     if (count == LAST_CNT) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    next_state = start ? PREP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        case (next_state)
            PREP, RUN, FIX: busy_nxt = 1'b1;
            DONE:           done_nxt = 1'b1;
            default:        ;
        endcase
    end

    // Operand latch, iteration datapath and sign-corrected result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r     <= OP_MULT;
            a_r      <= '0;
            b_r      <= '0;
            opnd     <= '0;
            acc      <= '0;
            count    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            lo       <= '0;
            hi       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_r     <= op_e'(op);
                        a_r      <= a;
                        b_r      <= b;
                        div_zero <= 1'b0;
                    end
                end
                PREP: begin
                    sign_a <= neg_a_c;
                    sign_b <= neg_b_c;
                    count  <= '0;
                    if (div_c) begin
                        acc  <= {{WIDTH{1'b0}}, mag_a_c};
                        opnd <= mag_b_c;
                    end else begin
                        acc  <= {{WIDTH{1'b0}}, mag_b_c};
                        opnd <= mag_a_c;
                    end
                end
                RUN: begin
                    acc   <= acc_iter | {{(2*WIDTH-1){1'b0}}, q_bit};
                    count <= count + CNT_W'(1);
                end
                FIX: begin
                    if (dz_c) begin
                        lo       <= '1;
                        hi       <= a_r;
                        div_zero <= 1'b1;
                    end else if (!div_c) begin
                        {hi, lo} <= (sign_a ^ sign_b) ? -acc : acc;
                    end else begin
                        lo <= (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi <= sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] lo, hi;
    logic        busy, done, div_zero;

    int errors = 0;
    int checks = 0;

    mul_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .lo       (lo),
        .hi       (hi),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    // Starts an op and waits (bounded) for done; returns at the negedge of the done cycle.
    task automatic run_op(input logic now, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic busy_ok, output logic stable);
        logic [31:0] lo0, hi0;
        if (!now) @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        lo0 = lo; hi0 = hi;
        lat = 0; busy_ok = 1'b1; stable = 1'b1;
        while (done !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (lo !== lo0 || hi !== hi0) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++; if ({lo, hi} !== 64'h0) begin errors++; $display("FAIL reset_lohi: got %h required 0", {lo, hi}); end
        checks++; if ({busy, done, div_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b required 000", {busy, done, div_zero}); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_max();
        int lat; logic bok, stb;
        run_op(1'b0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok, stb);
        checks++; if (lat !== 34) begin errors++; $display("FAIL multu_latency: got %0d required 34", lat); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL multu_busy_run: got %b required 1", bok); end
        checks++; if (stb !== 1'b1) begin errors++; $display("FAIL multu_hold_during_run: got %b required 1", stb); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h required fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h required 00000001", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_done: got %b required 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b required 0", done); end
    endtask

    task automatic test_mult_signed();
        int lat; logic bok, stb;
        run_op(1'b0, OP_MULT, 32'hFFFF_FFF9, 32'd3, lat, bok, stb);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_neg: got %h required ffffffffffffffeb", {hi, lo}); end
    endtask

    task automatic test_div_signed();
        int lat; logic bok, stb;
        run_op(1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bok, stb);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_q: got %h required fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_r: got %h required ffffffff", hi); end
        run_op(1'b0, OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, bok, stb);
        checks++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_negdivisor: got %h required 00000001fffffffd", {hi, lo}); end
    endtask

    task automatic test_divu();
        int lat; logic bok, stb;
        run_op(1'b0, OP_DIVU, 32'd100, 32'd7, lat, bok, stb);
        checks++; if (lat !== 34) begin errors++; $display("FAIL divu_latency: got %0d required 34", lat); end
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_result: got %h required 000000020000000e", {hi, lo}); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL divu_divzero: got %b required 0", div_zero); end
    endtask

    task automatic test_div_overflow();
        int lat; logic bok, stb;
        run_op(1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok, stb);
        checks++; if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin errors++; $display("FAIL div_overflow: got %h required 0000000080000000", {hi, lo}); end
    endtask

    task automatic test_div_zero();
        int lat; logic bok, stb;
        run_op(1'b0, OP_DIVU, 32'd1234, 32'd0, lat, bok, stb);
        checks++; if (lat !== 2) begin errors++; $display("FAIL divzero_latency: got %0d required 2", lat); end
        checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL divzero_flag: got %b required 1", div_zero); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divzero_lo: got %h required ffffffff", lo); end
        checks++; if (hi !== 32'd1234) begin errors++; $display("FAIL divzero_hi: got %h required 000004d2", hi); end
        run_op(1'b0, OP_MULTU, 32'd2, 32'd3, lat, bok, stb);
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL divzero_clear: got %b required 0", div_zero); end
        checks++; if ({hi, lo} !== 64'd6) begin errors++; $display("FAIL multu_small: got %h required 6", {hi, lo}); end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = 32'd1000; b = 32'd1000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 10) begin start = 1'b1; a = 32'd5; b = 32'd5; end
            else start = 1'b0;
        end
        start = 1'b0;
        checks++; if (lat !== 34) begin errors++; $display("FAIL ignore_latency: got %0d required 34", lat); end
        checks++; if ({hi, lo} !== 64'd1000000) begin errors++; $display("FAIL ignore_result: got %h required f4240", {hi, lo}); end
    endtask

    task automatic test_back_to_back();
        int lat; logic bok, stb;
        run_op(1'b0, OP_MULTU, 32'h0001_0000, 32'h0001_0000, lat, bok, stb);
        checks++; if ({hi, lo} !== {32'd1, 32'd0}) begin errors++; $display("FAIL b2b_first: got %h required 0000000100000000", {hi, lo}); end
        run_op(1'b1, OP_DIVU, 32'd100, 32'd7, lat, bok, stb);
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency: got %0d required 34", lat); end
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL b2b_second: got %h required 000000020000000e", {hi, lo}); end
    endtask

    task automatic test_reset_mid();
        int lat; logic bok, stb;
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b required 1", busy); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midreset_flags: got %b required 00", {busy, done}); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL midreset_lohi: got %h required 0", {hi, lo}); end
        @(negedge clk);
        reset = 1'b1;
        run_op(1'b0, OP_DIVU, 32'd9, 32'd4, lat, bok, stb);
        checks++; if ({hi, lo} !== {32'd1, 32'd2}) begin errors++; $display("FAIL after_reset_divu: got %h required 0000000100000002", {hi, lo}); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_div_signed();
        test_divu();
        test_div_overflow();
        test_div_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
